sd_read: RTL



---
 rtl/sd_read.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_read.sv
// SPI-mode single-block reader (CMD17): sends the command, checks R1, waits for the start
// token and streams 512 bytes out as 256 words. Optional CRC16 check under SD_READ_CRC_EN.
module sd_read #(
  parameter int unsigned R1_TIMEOUT    = 64,
  parameter int unsigned TOKEN_TIMEOUT = 65535,
  parameter int unsigned TAIL_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_miso,
  input  logic        sd_init_done,
  input  logic        read_ready,
  input  logic [31:0] read_address,
  output logic        sd_cs,
  output logic        sd_mosi,
  output logic        read_busy,
  output logic [15:0] read_data,
  output logic        read_valid,
  output logic        read_done,
  output logic        read_error
);

  typedef enum logic [2:0] {
    StIdle, StSendCmd, StWaitR1, StWaitToken, StRecvData, StRecvCrc, StFinish
  } state_e;

  localparam logic [15:0] R1Last   = 16'(R1_TIMEOUT - 1);
  localparam logic [15:0] TokLast  = 16'(TOKEN_TIMEOUT - 1);
  localparam logic [15:0] TailLast = 16'(TAIL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [47:0] cmd_q, cmd_d;
  logic [5:0]  cmd_cnt_q, cmd_cnt_d;
  logic [3:0]  r1_cnt_q, r1_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [15:0] tail_cnt_q, tail_cnt_d;
  logic        err_q, err_d;
  logic        cs_q, cs_d, mosi_q, mosi_d, busy_q, busy_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d, done_q, done_d, rerr_q, rerr_d;
  logic [47:0] cmd_full;
  logic [15:0] to_inc;
  logic        fin, fin_err;
`ifdef SD_READ_CRC_EN
  logic [15:0] crc_q, crc_d;
`endif

  assign cmd_full = {8'h51, read_address, 8'hFF};
  assign to_inc   = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;

  always_comb begin
    shift_d    = {shift_q[14:0], sd_miso};
    state_d    = state_q;
    cmd_d      = cmd_q;
    cmd_cnt_d  = cmd_cnt_q;
    r1_cnt_d   = r1_cnt_q;
    to_cnt_d   = to_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    tail_cnt_d = tail_cnt_q;
    err_d      = err_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    rerr_d     = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;
`ifdef SD_READ_CRC_EN
    crc_d      = crc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (read_ready && sd_init_done) begin
          mosi_d    = cmd_full[47];
          cmd_d     = {cmd_full[46:0], 1'b1};
          cmd_cnt_d = 6'd1;
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          state_d   = StSendCmd;
        end
      end
      StSendCmd: begin
        if (cmd_cnt_q == 6'd48) begin
          mosi_d   = 1'b1;
          to_cnt_d = '0;
          r1_cnt_d = '0;
          state_d  = StWaitR1;
        end else begin
          mosi_d    = cmd_q[47];
          cmd_d     = {cmd_q[46:0], 1'b1};
          cmd_cnt_d = cmd_cnt_q + 6'd1;
        end
      end
      StWaitR1: begin
        // Timeout applies only to the start bit, so a completing R1 always wins.
        if (r1_cnt_q != 4'd0) begin
          r1_cnt_d = r1_cnt_q + 4'd1;
          if (r1_cnt_q == 4'd7) begin
            if (shift_d[7:0] == 8'h00) begin
              to_cnt_d = '0;
              state_d  = StWaitToken;
            end else begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          end
        end else if (!sd_miso) begin
          r1_cnt_d = 4'd1;
        end else if (to_cnt_q == R1Last) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      StWaitToken: begin
        to_cnt_d = to_inc;
        // Only judge the window once it holds 8 bits received after R1.
        if (to_cnt_q >= 16'd7 && shift_d[7:0] == 8'hFE) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = StRecvData;
`ifdef SD_READ_CRC_EN
          crc_d      = '0;
`endif
        end else if ((to_cnt_q >= 16'd7 && shift_d[7:4] == 4'h0) || to_cnt_q == TokLast) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      StRecvData: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef SD_READ_CRC_EN
        crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ sd_miso) ? 16'h1021 : 16'h0000);
`endif
        if (bit_cnt_q == 4'd15) begin
          data_d     = shift_d;
          valid_d    = 1'b1;
          word_cnt_d = word_cnt_q + 8'd1;
          if (word_cnt_q == 8'd255) state_d = StRecvCrc;
        end
      end
      StRecvCrc: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          fin = 1'b1;
`ifdef SD_READ_CRC_EN
          fin_err = (shift_d != crc_q);
`endif
        end
      end
      StFinish: begin
        tail_cnt_d = tail_cnt_q + 16'd1;
        if (tail_cnt_q == TailLast) begin
          done_d  = 1'b1;
          rerr_d  = err_q;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fin) begin
      state_d    = StFinish;
      cs_d       = 1'b1;
      mosi_d     = 1'b1;
      tail_cnt_d = '0;
      if (fin_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cmd_q      <= '0;
      cmd_cnt_q  <= '0;
      r1_cnt_q   <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tail_cnt_q <= '0;
      err_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b1;
      busy_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      rerr_q     <= 1'b0;
`ifdef SD_READ_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      cmd_cnt_q  <= cmd_cnt_d;
      r1_cnt_q   <= r1_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      err_q      <= err_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      rerr_q     <= rerr_d;
`ifdef SD_READ_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign sd_cs      = cs_q;
  assign sd_mosi    = mosi_q;
  assign read_busy  = busy_q;
  assign read_data  = data_q;
  assign read_valid = valid_q;
  assign read_done  = done_q;
  assign read_error = rerr_q;

endmodule
